// File: rtl/combo_arb_pkg.sv
// Shared types and constants for the combo arbiter slice.
// Optional build macro honoured by the slice: COMBO_ARB_PRIO_EN.
package combo_arb_pkg;

    localparam int OPND_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/combo_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/combo_arbiter.sv
// Arbitrates NREQ requesters onto one shared combo/dff/mux datapath, one operation at a time.
// Define COMBO_ARB_PRIO_EN to give requester 0 absolute priority over the round-robin group.
module combo_arbiter
    import combo_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [OPND_W*NREQ-1:0]   opnd,
    output logic [NREQ-1:0]          gnt,
    output logic [OPND_W-1:0]        dp_abcd,
    input  logic                     dp_f,
    output logic                     busy,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     rsp_f
);

    localparam int IDX_W = $clog2(NREQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPND_W-1:0]  opnd_q, opnd_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rspId_q, rspId_d;
    logic               rspF_q, rspF_d;

    logic [NREQ-1:0]    rrReq, rrGnt, winGnt;
    logic [IDX_W-1:0]   rrIdx, winIdx;
    logic               rrValid, winValid, prioWin;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) uPick (
        .req_i   (rrReq),
        .ptr_i   (ptr_q),
        .gnt_o   (rrGnt),
        .idx_o   (rrIdx),
        .valid_o (rrValid)
    );

`ifdef COMBO_ARB_PRIO_EN
    // Requester 0 bypasses the rotation entirely, so it must not touch ptr.
    assign rrReq = {req[NREQ-1:1], 1'b0};

    always_comb begin
        winGnt   = rrGnt;
        winIdx   = rrIdx;
        winValid = rrValid;
        prioWin  = 1'b0;
        if (req[0]) begin
            winGnt   = NREQ'(1);
            winIdx   = '0;
            winValid = 1'b1;
            prioWin  = 1'b1;
        end
    end
`else
    assign rrReq    = req;
    assign winGnt   = rrGnt;
    assign winIdx   = rrIdx;
    assign winValid = rrValid;
    assign prioWin  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            idx_q   <= '0;
            rspId_q <= '0;
            rspF_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            idx_q   <= idx_d;
            rspId_q <= rspId_d;
            rspF_q  <= rspF_d;
        end
    end

    // Grant is combinational in IDLE and gated by rst so nothing leaks out while reset is held.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        idx_d     = idx_q;
        rspId_d   = rspId_q;
        rspF_d    = rspF_q;
        gnt       = '0;
        rsp_valid = 1'b0;
        rsp_id    = rspId_q;
        rsp_f     = rspF_q;
        busy      = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (winValid && !rst) begin
                    gnt     = winGnt;
                    opnd_d  = opnd[OPND_W*winIdx +: OPND_W];
                    idx_d   = winIdx;
                    cnt_d   = CNT_W'(SETTLE);
                    state_d = RUN;
                    if (!prioWin) begin
                        ptr_d = (winIdx == IDX_W'(NREQ-1)) ? '0 : winIdx + IDX_W'(1);
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_id    = idx_q;
                rsp_f     = dp_f;
                rspId_d   = idx_q;
                rspF_d    = dp_f;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dp_abcd = opnd_q;

endmodule

// File: tb/tb_combo_arbiter.sv
// Directed bench for combo_arbiter with a one-flop reference datapath model on dp_f.
`timescale 1ns/1ps
module tb_combo_arbiter;

    localparam int NREQ   = 4;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] opnd;
    logic [NREQ-1:0]   gnt;
    logic [3:0]        dp_abcd;
    logic              dp_f;
    logic              busy;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic              rsp_f;

    int nCompared   = 0;
    int nMismatched = 0;

    combo_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .opnd      (opnd),
        .gnt       (gnt),
        .dp_abcd   (dp_abcd),
        .dp_f      (dp_f),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_f     (rsp_f)
    );

    always #5 clk = ~clk;

    // Reference datapath: f = (a&b) | (c^d), registered once.
    function automatic logic fModel(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] ^ v[0]);
    endfunction

    function automatic logic [3:0] opndOf(input int i);
        case (i)
            0:       return 4'b0011;
            1:       return 4'b1100;
            2:       return 4'b0110;
            default: return 4'b1001;
        endcase
    endfunction

    logic dpReg;
    always @(posedge clk) dpReg <= fModel(dp_abcd);
    assign dp_f = dpReg;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        step();
        step();
        #1;
        nCompared++; if (gnt !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        nCompared++; if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        nCompared++; if (rsp_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        nCompared++; if (rsp_f !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rsp_f: got %b expected 0", rsp_f); end
        nCompared++; if (dp_abcd !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_dp_abcd: got %b expected 0000", dp_abcd); end
        req = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_single();
        doReset();
        req = 4'b0001;
        #1;
        nCompared++; if (gnt !== 4'b0001) begin nMismatched++; $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); end
        for (int s = 1; s <= SETTLE; s++) begin
            step();
            req = 4'b0000;
            #1;
            nCompared++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || gnt !== 4'b0000) begin nMismatched++; $display("[TB] FAIL single_run%0d: got busy=%b valid=%b gnt=%b expected 1 0 0000", s, busy, rsp_valid, gnt); end
            nCompared++; if (dp_abcd !== 4'b0011) begin nMismatched++; $display("[TB] FAIL single_dp_abcd: got %b expected 0011", dp_abcd); end
        end
        step();
        nCompared++; if (rsp_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        nCompared++; if (rsp_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL single_rsp_id: got %0d expected 0", rsp_id); end
        nCompared++; if (rsp_f !== fModel(4'b0011)) begin nMismatched++; $display("[TB] FAIL single_rsp_f: got %b expected %b", rsp_f, fModel(4'b0011)); end
        step();
        nCompared++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL single_idle: got valid=%b busy=%b id=%0d expected 0 0 0", rsp_valid, busy, rsp_id); end
    endtask

`ifndef COMBO_ARB_PRIO_EN
    task automatic test_round_robin();
        doReset();
        req = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % NREQ;
            nCompared++; if (gnt !== 4'(1 << e)) begin nMismatched++; $display("[TB] FAIL rr_gnt%0d: got %b expected %b", g, gnt, 4'(1 << e)); end
            for (int s = 1; s <= SETTLE; s++) begin
                step();
                nCompared++; if (gnt !== 4'b0000 || rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rr_busy%0d: got gnt=%b valid=%b expected 0000 0", g, gnt, rsp_valid); end
            end
            step();
            nCompared++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e)) begin nMismatched++; $display("[TB] FAIL rr_rsp%0d: got valid=%b id=%0d expected 1 %0d", g, rsp_valid, rsp_id, e); end
            nCompared++; if (rsp_f !== fModel(opndOf(e))) begin nMismatched++; $display("[TB] FAIL rr_rsp_f%0d: got %b expected %b", g, rsp_f, fModel(opndOf(e))); end
            step();
        end
        req = 4'b0000;
    endtask
`endif

    task automatic test_drop();
        doReset();
        req = 4'b0101;
        #1;
        nCompared++; if (gnt !== 4'b0001) begin nMismatched++; $display("[TB] FAIL drop_gnt0: got %b expected 0001", gnt); end
        for (int s = 1; s <= SETTLE; s++) step();
        step();
        req = 4'b0001;
        #1;
        nCompared++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL drop_rsp: got valid=%b id=%0d expected 1 0", rsp_valid, rsp_id); end
        step();
        nCompared++; if (gnt !== 4'b0001) begin nMismatched++; $display("[TB] FAIL drop_no_req2: got %b expected 0001", gnt); end
        step();
        req = 4'b0101;
        #1;
        nCompared++; if (gnt !== 4'b0000) begin nMismatched++; $display("[TB] FAIL drop_busy_ignored: got %b expected 0000", gnt); end
        for (int s = 1; s <= SETTLE + 1; s++) step();
`ifdef COMBO_ARB_PRIO_EN
        nCompared++; if (gnt !== 4'b0001) begin nMismatched++; $display("[TB] FAIL drop_regrant: got %b expected 0001", gnt); end
`else
        nCompared++; if (gnt !== 4'b0100) begin nMismatched++; $display("[TB] FAIL drop_regrant: got %b expected 0100", gnt); end
`endif
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_run();
        doReset();
        req = 4'b1000;
        #1;
        nCompared++; if (gnt !== 4'b1000) begin nMismatched++; $display("[TB] FAIL mid_gnt3: got %b expected 1000", gnt); end
        for (int s = 1; s <= SETTLE; s++) step();
        step();
        nCompared++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_f !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_rsp3: got valid=%b id=%0d f=%b expected 1 3 1", rsp_valid, rsp_id, rsp_f); end
        step();
        req = 4'b0010;
        #1;
        nCompared++; if (gnt !== 4'b0010) begin nMismatched++; $display("[TB] FAIL mid_gnt1: got %b expected 0010", gnt); end
        step();
        req = 4'b1010;
        rst = 1'b1;
        #1;
        nCompared++; if (busy !== 1'b0 || gnt !== 4'b0000 || rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_ctl: got busy=%b gnt=%b valid=%b expected 0 0000 0", busy, gnt, rsp_valid); end
        nCompared++; if (rsp_id !== 2'd0 || rsp_f !== 1'b0 || dp_abcd !== 4'b0000) begin nMismatched++; $display("[TB] FAIL mid_rst_data: got id=%0d f=%b abcd=%b expected 0 0 0000", rsp_id, rsp_f, dp_abcd); end
        for (int s = 1; s <= SETTLE + 1; s++) begin
            step();
            nCompared++; if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin nMismatched++; $display("[TB] FAIL mid_rst_hold%0d: got valid=%b gnt=%b expected 0 0000", s, rsp_valid, gnt); end
        end
        rst = 1'b0;
        #1;
        nCompared++; if (gnt !== 4'b0010) begin nMismatched++; $display("[TB] FAIL mid_after_rst: got %b expected 0010", gnt); end
        req = 4'b0000;
    endtask

`ifdef COMBO_ARB_PRIO_EN
    task automatic test_prio();
        int expSeq [7] = '{0, 0, 0, 1, 3, 1, 3};
        doReset();
        req = 4'b1011;
        #1;
        for (int g = 0; g < 7; g++) begin
            nCompared++; if (gnt !== 4'(1 << expSeq[g])) begin nMismatched++; $display("[TB] FAIL prio_gnt%0d: got %b expected %b", g, gnt, 4'(1 << expSeq[g])); end
            step();
            if (g == 2) req = 4'b1010;
            for (int s = 1; s <= SETTLE + 1; s++) step();
        end
        req = 4'b0000;
    endtask
`endif

    initial begin
        rst  = 1'b1;
        req  = '0;
        opnd = {opndOf(3), opndOf(2), opndOf(1), opndOf(0)};
        test_reset();
        test_single();
`ifdef COMBO_ARB_PRIO_EN
        test_prio();
`else
        test_round_robin();
`endif
        test_drop();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
